// File: rtl/masked_aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : masked_aes_pkg
//  Description : Shared constants and types for the masked AES SubBytes
//                sequencer and its share collectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package masked_aes_pkg;

    localparam int NUM_BYTES        = 16;
    localparam int BYTE_W           = 8;
    localparam int STATE_W          = NUM_BYTES * BYTE_W;
    localparam int IDX_W            = $clog2(NUM_BYTES);
    localparam int OFS_W            = $clog2(STATE_W);
    localparam int CNT_W            = 5;
    localparam int SBOX_LAT_DEFAULT = 4;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

endpackage : masked_aes_pkg
`default_nettype wire

// File: rtl/share_byte_collector.sv
`default_nettype none
// ============================================================================
//  Module      : share_byte_collector
//  Description : 128-bit capture register for one share; writes a single
//                byte lane selected by a byte index. One instance per share,
//                so the shares never meet in common logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module share_byte_collector
    import masked_aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [BYTE_W-1:0]  din,
    output logic [STATE_W-1:0] data
);

    logic [NUM_BYTES-1:0] w_byte_we;
    logic [STATE_W-1:0]   data_d;
    logic [STATE_W-1:0]   data_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            assign w_byte_we[gi] = we && (idx == IDX_W'(gi));
        end
    endgenerate

    // Merge the incoming byte into its lane; other lanes keep their value
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_byte_we[i]) begin
                data_d[i*BYTE_W +: BYTE_W] = din;
            end
        end
    end

    // Capture register, cleared by reset so no stale share survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule : share_byte_collector
`default_nettype wire

// File: rtl/masked_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : masked_subbytes_seq
//  Description : Two-share sequencer feeding the masked AES S-box one byte
//                per cycle, tracking pipeline bubbles with a tag line and
//                reassembling result shares into 128-bit output registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module masked_subbytes_seq
    import masked_aes_pkg::*;
#(
    parameter int SBOX_LAT = SBOX_LAT_DEFAULT,
    parameter int RND_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_s0,
    input  logic [STATE_W-1:0] in_s1,
    input  logic [RND_W-1:0]   rnd,
    input  logic               rnd_valid,
    output logic               rnd_ack,
    output logic [BYTE_W-1:0]  sbox_in0,
    output logic [BYTE_W-1:0]  sbox_in1,
    output logic [RND_W-1:0]   sbox_r,
    output logic               sbox_en,
    input  logic [BYTE_W-1:0]  sbox_out0,
    input  logic [BYTE_W-1:0]  sbox_out1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_s0,
    output logic [STATE_W-1:0] out_s1
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(NUM_BYTES);

    seq_state_e           state_d, state_q;
    logic [CNT_W-1:0]     issue_cnt_d, issue_cnt_q;
    logic [CNT_W-1:0]     coll_cnt_d, coll_cnt_q;
    logic [SBOX_LAT-1:0]  tag_d, tag_q;
    logic [STATE_W-1:0]   in0_d, in0_q;
    logic [STATE_W-1:0]   in1_d, in1_q;
    logic [BYTE_W-1:0]    byte0_d, byte0_q;
    logic [BYTE_W-1:0]    byte1_d, byte1_q;

    logic [OFS_W-1:0]     w_bit_ofs;
    logic [BYTE_W-1:0]    w_sel0, w_sel1;
    logic                 w_issue;
    logic                 w_capture;

    // Byte selection is steered by the issue counter only, separately per share
    always_comb begin
        w_bit_ofs = {issue_cnt_q[IDX_W-1:0], 3'b000};
        w_sel0    = in0_q[w_bit_ofs +: BYTE_W];
        w_sel1    = in1_q[w_bit_ofs +: BYTE_W];
    end

    // Next-state, counters, tag line and handshake outputs
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        coll_cnt_d  = coll_cnt_q;
        tag_d       = tag_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;

        w_issue   = (state_q == ST_FEED) && rnd_valid && (issue_cnt_q < c_cnt_full);
        sbox_en   = (state_q == ST_FEED) || ((state_q == ST_DRAIN) && (|tag_q));
        w_capture = sbox_en && tag_q[SBOX_LAT-1] && (coll_cnt_q < c_cnt_full);

        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_HOLD);
        rnd_ack   = w_issue;

        // Held byte registers keep the gadget inputs quiet during bubbles
        sbox_in0  = w_issue ? w_sel0 : byte0_q;
        sbox_in1  = w_issue ? w_sel1 : byte1_q;

        if (w_issue) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            byte0_d     = w_sel0;
            byte1_d     = w_sel1;
        end
        if (w_capture) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
        // Tag line advances in lockstep with the gated S-box pipeline
        if (sbox_en) begin
            tag_d = (tag_q << 1) | SBOX_LAT'(w_issue);
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in0_d       = in_s0;
                    in1_d       = in_s1;
                    issue_cnt_d = '0;
                    coll_cnt_d  = '0;
                    state_d     = ST_FEED;
                end
            end
            ST_FEED: begin
                if (w_issue && (issue_cnt_q == c_cnt_last)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Enter HOLD together with the last capture edge
                if (coll_cnt_d == c_cnt_full) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, tag line and per-share input registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            coll_cnt_q  <= '0;
            tag_q       <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            byte0_q     <= '0;
            byte1_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            coll_cnt_q  <= coll_cnt_d;
            tag_q       <= tag_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
        end
    end

    assign sbox_r = rnd;

    share_byte_collector u_coll_s0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_capture),
        .idx   (coll_cnt_q[IDX_W-1:0]),
        .din   (sbox_out0),
        .data  (out_s0)
    );

    share_byte_collector u_coll_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_capture),
        .idx   (coll_cnt_q[IDX_W-1:0]),
        .din   (sbox_out1),
        .data  (out_s1)
    );

endmodule : masked_subbytes_seq
`default_nettype wire

// File: tb/tb_masked_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_masked_subbytes_seq
//  Description : Testbench for masked_subbytes_seq with a behavioural
//                two-share S-box pipeline and a table-based SubBytes model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_subbytes_seq;

    localparam int L     = 4;
    localparam int RND_W = 8;
    localparam int LAT0  = 17 + L;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [127:0] in_s0, in_s1;
    logic [7:0]   rnd;
    logic         rnd_valid, rnd_ack;
    logic [7:0]   sbox_in0, sbox_in1;
    logic [7:0]   sbox_r;
    logic         sbox_en;
    logic [7:0]   sbox_out0, sbox_out1;
    logic         out_valid, out_ready;
    logic [127:0] out_s0, out_s1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int ack_total  = 0;

    logic [7:0]   sbox_tbl [256];
    logic [7:0]   p0 [L];
    logic [7:0]   p1 [L];

    // results of the most recent run
    logic [127:0] res0, res1;
    int           lat, acks;
    bit           timeout, busy_ready;

    masked_subbytes_seq #(.SBOX_LAT(L), .RND_W(RND_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .rnd(rnd), .rnd_valid(rnd_valid),
        .rnd_ack(rnd_ack), .sbox_in0(sbox_in0), .sbox_in1(sbox_in1),
        .sbox_r(sbox_r), .sbox_en(sbox_en), .sbox_out0(sbox_out0),
        .sbox_out1(sbox_out1), .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] subbytes_ref(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tbl[st[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural masked S-box: L-stage gated pipeline, fresh output mask per input
    always @(posedge clk or negedge rst_n) begin
        logic [7:0] m;
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin p0[i] <= 8'h00; p1[i] <= 8'h00; end
        end else if (sbox_en) begin
            m = 8'($urandom);
            p0[0] <= sbox_tbl[sbox_in0 ^ sbox_in1] ^ m;
            p1[0] <= m;
            for (int i = 1; i < L; i++) begin p0[i] <= p0[i-1]; p1[i] <= p1[i-1]; end
        end
    end
    assign sbox_out0 = p0[L-1];
    assign sbox_out1 = p1[L-1];

    // Cycle and randomness-consumption counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rnd_ack) ack_total <= ack_total + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_state(input logic [127:0] s0, input logic [127:0] s1,
                             input int stall_after, input int stall_len,
                             input bit busy_pulse, input logic [127:0] b0,
                             input logic [127:0] b1);
        int issued, stall_rem, e0, a0, guard;
        bit stalled, busied;
        timeout = 0; busy_ready = 0;
        issued = 0; stall_rem = 0; stalled = 0; busied = 0; guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!in_ready) timeout = 1;
        a0 = ack_total;
        in_s0 = s0; in_s1 = s1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        e0 = cyc;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 300) begin
            if (busy_pulse && in_valid) begin
                busy_ready = busy_ready | in_ready;
                in_valid = 1'b0;
            end
            if (rnd_ack) issued++;
            if (stall_rem > 0) begin
                stall_rem--;
                if (stall_rem == 0) rnd_valid = 1'b1;
            end else if (!stalled && stall_after >= 0 && rnd_ack && issued == stall_after + 1) begin
                rnd_valid = 1'b0; stall_rem = stall_len; stalled = 1;
            end
            if (busy_pulse && !busied && issued == 16) begin
                in_s0 = b0; in_s1 = b1; in_valid = 1'b1; busied = 1;
            end
            rnd = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (!out_valid) timeout = 1;
        lat  = cyc - e0 + 1;
        res0 = out_s0; res1 = out_s1;
        acks = ack_total - a0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rnd_valid = 1'b1; rnd = 8'h5a;
        @(negedge clk);
        compared++; if (in_ready !== 1'b1)   begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        compared++; if (out_valid !== 1'b0)  begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++; if (rnd_ack !== 1'b0)    begin mismatched++; $display("FAIL reset_rnd_ack: got %b want 0", rnd_ack); end
        compared++; if (sbox_en !== 1'b0)    begin mismatched++; $display("FAIL reset_sbox_en: got %b want 0", sbox_en); end
        compared++; if (out_s0 !== 128'h0 || out_s1 !== 128'h0)
            begin mismatched++; $display("FAIL reset_out_s: got %h / %h want 0", out_s0, out_s1); end
        compared++; if (sbox_in0 !== 8'h00 || sbox_in1 !== 8'h00)
            begin mismatched++; $display("FAIL reset_sbox_in: got %h / %h want 0", sbox_in0, sbox_in1); end
        compared++; if (sbox_r !== 8'h5a)    begin mismatched++; $display("FAIL sbox_r_passthru: got %h want 5a", sbox_r); end
    endtask

    task automatic test_zero_state();
        logic [127:0] m;
        m = rand128();
        run_state(m, m, -1, 0, 0, '0, '0);
        compared++; if (timeout !== 1'b0) begin mismatched++; $display("FAIL zero_timeout: got %b want 0", timeout); end
        compared++; if ((res0 ^ res1) !== {16{8'h63}})
            begin mismatched++; $display("FAIL zero_result: got %h want %h", res0 ^ res1, {16{8'h63}}); end
        compared++; if (lat !== LAT0) begin mismatched++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT0); end
        compared++; if (acks !== 16) begin mismatched++; $display("FAIL zero_acks: got %0d want 16", acks); end
        release_out();
    endtask

    task automatic test_fips();
        logic [127:0] st, m, r;
        st = 128'h0;
        st[7:0] = 8'h53; st[127:120] = 8'h01;
        m = rand128();
        run_state(st ^ m, m, -1, 0, 0, '0, '0);
        r = res0 ^ res1;
        compared++; if (r[7:0] !== 8'hED)     begin mismatched++; $display("FAIL fips_byte0: got %h want ed", r[7:0]); end
        compared++; if (r[15:8] !== 8'h63)    begin mismatched++; $display("FAIL fips_byte1: got %h want 63", r[15:8]); end
        compared++; if (r[127:120] !== 8'h7C) begin mismatched++; $display("FAIL fips_byte15: got %h want 7c", r[127:120]); end
        compared++; if (r !== subbytes_ref(st)) begin mismatched++; $display("FAIL fips_full: got %h want %h", r, subbytes_ref(st)); end
        release_out();
    endtask

    task automatic test_rnd_stall();
        logic [127:0] st, m;
        st = rand128(); m = rand128();
        run_state(st ^ m, m, 5, 3, 0, '0, '0);
        compared++; if ((res0 ^ res1) !== subbytes_ref(st))
            begin mismatched++; $display("FAIL stall_result: got %h want %h", res0 ^ res1, subbytes_ref(st)); end
        compared++; if (lat !== LAT0 + 3) begin mismatched++; $display("FAIL stall_latency: got %0d want %0d", lat, LAT0 + 3); end
        compared++; if (acks !== 16) begin mismatched++; $display("FAIL stall_acks: got %0d want 16", acks); end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [127:0] st, m;
        st = rand128(); m = rand128();
        run_state(st ^ m, m, -1, 0, 0, '0, '0);
        compared++; if ((res0 ^ res1) !== subbytes_ref(st))
            begin mismatched++; $display("FAIL bp_result: got %h want %h", res0 ^ res1, subbytes_ref(st)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            compared++; if (out_s0 !== res0 || out_s1 !== res1)
                begin mismatched++; $display("FAIL bp_hold_stable[%0d]: got %h / %h want %h / %h", i, out_s0, out_s1, res0, res1); end
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        release_out();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1)  begin mismatched++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_feed();
        logic [127:0] st, m;
        int issued, guard;
        st = rand128(); m = rand128();
        @(negedge clk);
        in_s0 = st ^ m; in_s1 = m; in_valid = 1'b1; rnd_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        issued = 0; guard = 0;
        while (issued < 8 && guard < 100) begin
            if (rnd_ack) issued++;
            if (issued < 8) @(negedge clk);
            guard++;
        end
        compared++; if (issued !== 8) begin mismatched++; $display("FAIL rst_mid_progress: got %0d want 8", issued); end
        rst_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        compared++; if (out_s0 !== 128'h0 || out_s1 !== 128'h0)
            begin mismatched++; $display("FAIL rst_mid_out_s: got %h / %h want 0", out_s0, out_s1); end
        compared++; if (sbox_en !== 1'b0 || rnd_ack !== 1'b0)
            begin mismatched++; $display("FAIL rst_mid_ctrl: got en=%b ack=%b want 0/0", sbox_en, rnd_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        st = rand128(); m = rand128();
        run_state(st ^ m, m, -1, 0, 0, '0, '0);
        compared++; if ((res0 ^ res1) !== subbytes_ref(st))
            begin mismatched++; $display("FAIL rst_mid_fresh: got %h want %h", res0 ^ res1, subbytes_ref(st)); end
        compared++; if (lat !== LAT0) begin mismatched++; $display("FAIL rst_mid_latency: got %0d want %0d", lat, LAT0); end
        release_out();
    endtask

    task automatic test_busy_ignore();
        logic [127:0] st, m, st2;
        st = rand128(); m = rand128(); st2 = ~st;
        run_state(st ^ m, m, -1, 0, 1, st2, rand128());
        compared++; if (busy_ready !== 1'b0) begin mismatched++; $display("FAIL busy_in_ready: got %b want 0", busy_ready); end
        compared++; if ((res0 ^ res1) !== subbytes_ref(st))
            begin mismatched++; $display("FAIL busy_result: got %h want %h", res0 ^ res1, subbytes_ref(st)); end
        release_out();
        @(negedge clk);
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin mismatched++; $display("FAIL busy_back_idle: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_random();
        logic [127:0] st, m;
        int pos, len;
        for (int n = 0; n < 4; n++) begin
            st = rand128(); m = rand128();
            pos = $urandom_range(0, 14); len = $urandom_range(1, 4);
            run_state(st ^ m, m, pos, len, 0, '0, '0);
            compared++; if ((res0 ^ res1) !== subbytes_ref(st))
                begin mismatched++; $display("FAIL rand_result[%0d]: got %h want %h", n, res0 ^ res1, subbytes_ref(st)); end
            compared++; if (lat !== LAT0 + len)
                begin mismatched++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT0 + len); end
            compared++; if (acks !== 16)
                begin mismatched++; $display("FAIL rand_acks[%0d]: got %0d want 16", n, acks); end
            release_out();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_calc(8'(i));
        rst_n = 1'b0; in_valid = 1'b0; in_s0 = '0; in_s1 = '0;
        rnd = '0; rnd_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_zero_state();
        test_fips();
        test_rnd_stall();
        test_backpressure();
        test_reset_mid_feed();
        test_busy_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_masked_subbytes_seq
`default_nettype wire
